// File: rtl/fetch_predict_unit_if.sv
// Fetch-unit bundle: ICache request/response, Issue queue head, branch
// resolution and redirect. master = fetch unit, slave = its environment.
interface fetch_predict_unit_if;
  logic        ic_req;
  logic [31:0] ic_pc;
  logic        ic_valid;
  logic [31:0] ic_ins;

  logic        is_valid;
  logic        is_ready;
  logic [31:0] is_ins;
  logic [31:0] is_pc;
  logic        is_pred_taken;
  logic [31:0] is_alt_pc;

  logic        br_upd;
  logic [31:0] br_pc;
  logic        br_taken;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output ic_req, ic_pc, is_valid, is_ins, is_pc, is_pred_taken, is_alt_pc,
    input  ic_valid, ic_ins, is_ready, br_upd, br_pc, br_taken, flush, flush_pc
  );

  modport slave (
    input  ic_req, ic_pc, is_valid, is_ins, is_pc, is_pred_taken, is_alt_pc,
    output ic_valid, ic_ins, is_ready, br_upd, br_pc, br_taken, flush, flush_pc
  );
endinterface

// File: rtl/fetch_predict_unit.sv
// Instruction fetch with a 2-bit-counter branch predictor and a fetched-
// instruction queue; one ICache request in flight at a time.
module fetch_predict_unit #(
  parameter int unsigned BHT_ENTRIES = 256,
  parameter int unsigned IQ_DEPTH    = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  fetch_predict_unit_if.master bus
);
  localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
  localparam int unsigned IQ_PW  = $clog2(IQ_DEPTH);
  localparam logic [IQ_PW:0]   IQ_FULL = (IQ_PW+1)'(IQ_DEPTH);
  localparam logic [IQ_PW:0]   CNT_ONE = (IQ_PW+1)'(1);
  localparam logic [IQ_PW-1:0] PTR_ONE = IQ_PW'(1);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] alt;
  } iq_entry_t;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [IQ_PW:0]   count_q, count_d;
  logic [IQ_PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  iq_entry_t        iq_q  [IQ_DEPTH];

  logic [6:0]        opcode;
  logic [31:0]       imm_b, imm_j, pc_plus4, next_pc;
  logic [BHT_IW-1:0] lookup_idx, upd_idx;
  logic              bht_pred, push, pop, is_valid;
  iq_entry_t         new_entry;
  logic              unused_br_pc_bits;

  assign opcode     = bus.ic_ins[6:0];
  assign imm_b      = {{20{bus.ic_ins[31]}}, bus.ic_ins[7], bus.ic_ins[30:25],
                       bus.ic_ins[11:8], 1'b0};
  assign imm_j      = {{12{bus.ic_ins[31]}}, bus.ic_ins[19:12], bus.ic_ins[20],
                       bus.ic_ins[30:21], 1'b0};
  assign pc_plus4   = pc_q + 32'd4;
  assign lookup_idx = pc_q[BHT_IW+1:2];
  assign upd_idx    = bus.br_pc[BHT_IW+1:2];
  // Reads the registered counter, so a same-cycle update is not yet visible.
  assign bht_pred   = bht_q[lookup_idx][1];
  assign is_valid   = (count_q != '0);
  assign unused_br_pc_bits = ^{bus.br_pc[31:BHT_IW+2], bus.br_pc[1:0]};

  // Prediction for the word returning from the ICache.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    new_entry = '{ins: bus.ic_ins, pc: pc_q, pred: 1'b0, alt: pc_plus4};
    next_pc   = pc_plus4;
    case (opcode)
      OP_BRANCH: begin
        new_entry.pred = bht_pred;
        next_pc        = bht_pred ? pc_q + imm_b : pc_plus4;
        new_entry.alt  = bht_pred ? pc_plus4 : pc_q + imm_b;
      end
      OP_JAL: begin
        new_entry.pred = 1'b1;
        next_pc        = pc_q + imm_j;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    bht_d    = bht_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (rdy) begin
      // Training is independent of redirects and happens on flush cycles too.
      if (bus.br_upd) begin
        if (bus.br_taken && bht_q[upd_idx] != 2'b11)
          bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
        else if (!bus.br_taken && bht_q[upd_idx] != 2'b00)
          bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
      if (bus.flush) begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        pc_d     = bus.flush_pc;
        // A response still owed by the ICache must be swallowed before refetching.
        state_d  = ((state_q == S_WAIT || state_q == S_DRAIN) && !bus.ic_valid)
                   ? S_DRAIN : S_REQ;
      end else begin
        pop = is_valid && bus.is_ready;
        case (state_q)
          S_REQ:   if (count_q != IQ_FULL) state_d = S_WAIT;
          S_WAIT:  if (bus.ic_valid) begin
                     push    = 1'b1;
                     pc_d    = next_pc;
                     state_d = (opcode == OP_JALR) ? S_HOLD : S_REQ;
                   end
          S_DRAIN: if (bus.ic_valid) state_d = S_REQ;
          S_HOLD:  ;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      bht_q    <= bht_d;
    end
  end

  // NOTE: queue payload has no reset; count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (push) iq_q[wr_ptr_q] <= new_entry;
  end

  assign bus.ic_req        = rst && rdy && !bus.flush && state_q == S_REQ &&
                             count_q != IQ_FULL;
  assign bus.ic_pc         = pc_q;
  assign bus.is_valid      = is_valid;
  assign bus.is_ins        = iq_q[rd_ptr_q].ins;
  assign bus.is_pc         = iq_q[rd_ptr_q].pc;
  assign bus.is_pred_taken = iq_q[rd_ptr_q].pred;
  assign bus.is_alt_pc     = iq_q[rd_ptr_q].alt;
endmodule

// File: doc/fetch_predict_unit.md
FETCH_PREDICT_UNIT -- requirements
Module: fetch_predict_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 256, number of 2-bit branch-history counters (power of 2, >=4).
REQ-002 SHALL have parameter IQ_DEPTH, default 8, number of entries in the fetched-instruction queue (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, PC fetched first after reset.
REQ-004 clk  in  1  single clock; all state rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rdy  in  1  global enable; 0 freezes all state.
REQ-007 ic_req  out  1  one-cycle fetch request pulse to ICache.
REQ-008 ic_pc  out  32  fetch address, valid when ic_req=1.
REQ-009 ic_valid  in  1  ICache response strobe for the outstanding request.
REQ-010 ic_ins  in  32  instruction word, valid when ic_valid=1.
REQ-011 is_valid  out  1  queue head valid to Issue.
REQ-012 is_ready  in  1  Issue accepts head this cycle.
REQ-013 is_ins / is_pc  out  32 each  head instruction and its PC.
REQ-014 is_pred_taken  out  1  head predicted taken (branch/JAL).
REQ-015 is_alt_pc  out  32  head recovery PC if prediction wrong.
REQ-016 br_upd  in  1  branch-resolution strobe from ALU.
REQ-017 br_pc  in  32  PC of resolved branch.
REQ-018 br_taken  in  1  actual outcome of resolved branch.
REQ-019 flush  in  1  redirect strobe (mispredict or JALR target).
REQ-020 flush_pc  in  32  redirect target.

Function
REQ-021 SHALL implement FSM states REQ, WAIT, DRAIN, HOLD.
REQ-022 In REQ with count<IQ_DEPTH: ic_req=1, ic_pc=pc, next state WAIT; with count==IQ_DEPTH, remain in REQ with ic_req=0.
REQ-023 At most one ICache request outstanding; ic_req SHALL never assert in WAIT, DRAIN or HOLD.
REQ-024 In WAIT on ic_valid: push entry {ic_ins, pc, pred, alt}, update pc to predicted next PC, go to REQ (HOLD if JALR).
REQ-025 Decode on opcode ic_ins[6:0]: branch 1100011, JAL 1101111, JALR 1100111; immediates per RV32I B/J formats, sign-extended, 32-bit wrap-around add.
REQ-026 Branch: pred=BHT[pc idx][1]; next=pred?pc+immB:pc+4; alt=pred?pc+4:pc+immB.
REQ-027 JAL: pred=1, next=pc+immJ, alt=pc+4.
REQ-028 JALR: pred=0, alt=pc+4, enter HOLD; leave HOLD only via flush.
REQ-029 All other opcodes: pred=0, next=pc+4, alt=pc+4.
REQ-030 BHT index = pc[log2(BHT_ENTRIES)+1:2]; same for br_pc on update.
REQ-031 On br_upd: counter saturating +1 if br_taken else -1 (range 0..3).
REQ-032 Lookup and update to same index in same cycle: lookup SHALL use pre-update value.
REQ-033 Queue FIFO: is_valid=(count!=0); pop when is_valid&&is_ready; push and pop same cycle leave count unchanged; pointers wrap modulo IQ_DEPTH.
REQ-034 flush (priority over all other events): queue emptied, pc<=flush_pc, state REQ; if a request is outstanding and ic_valid not in the same cycle, state DRAIN instead.
REQ-035 DRAIN: discard next ic_valid, then go REQ; no push.
REQ-036 flush coincident with ic_valid: response discarded, state REQ.
REQ-037 br_upd and flush SHALL be independent; BHT update still applied on a flush cycle.
REQ-038 rdy=0: no state change, ic_req=0, no pop; ic_valid arriving with rdy=0 is a protocol violation (not handled).

Reset
REQ-039 rst low (any time, incl. mid-request): pc=RESET_PC, state REQ, count=0, pointers 0, all BHT counters=2'b01, ic_req=0, is_valid=0; pending ICache response after release ignored only if ic_valid precedes first ic_req.
REQ-040 First ic_req SHALL assert in the first rdy=1 cycle after rst deasserts, with ic_pc=RESET_PC.

Verification
REQ-041 Reset, feed ADDI at 0,4,8 with 1-cycle ICache latency, is_ready=1 -> ic_pc 0,4,8; is_pc 0,4,8; is_pred_taken=0; is_alt_pc 4,8,12.
REQ-042 Branch at 0x10 imm +16, BHT reset -> next ic_pc 0x14, alt=0x20; after two br_upd taken for 0x10, refetch 0x10 -> ic_pc 0x20, pred=1, alt=0x14.
REQ-043 JAL at 0x0 imm -8 -> next ic_pc 0xFFFFFFF8 (wrap), alt=0x4; JALR -> ic_req stays 0 until flush flush_pc=0x100, then ic_pc=0x100.
REQ-044 is_ready=0, IQ_DEPTH=8 -> exactly 8 pushes then ic_req=0; one pop -> one new request; simultaneous push/pop keeps count 8.
REQ-045 flush in WAIT before ic_valid -> queue empty, stale response discarded (no push), next ic_pc=flush_pc; flush coincident with ic_valid -> no push, ic_req next cycle.
REQ-046 rst asserted mid-WAIT with full queue -> is_valid=0 immediately, first post-reset ic_pc=RESET_PC, BHT reads weakly-not-taken.
